// File: rtl/snn_pkg.sv
// Shared packet format and opcode helpers for the SNN convolution network nodes.
package snn_pkg;
    localparam int DEST_HI = 32;
    localparam int DEST_LO = 29;
    localparam int OP_HI   = 28;
    localparam int OP_LO   = 25;
    localparam int DATA_HI = 24;
    localparam int DATA_LO = 0;

    localparam logic [3:0] OP_TIMESTEP_DONE = 4'd15;

    typedef struct packed {
        logic [3:0]  dest;
        logic [3:0]  opcode;
        logic [24:0] data;
    } pkt_t;

    typedef enum logic [2:0] {ST_IDLE, ST_REPLY, ST_BCAST, ST_DRAIN, ST_DONE} omem_state_e;

    function automatic logic op_is_store(input logic [3:0] op);
        return ~op[0];
    endfunction

    function automatic logic [2:0] op_spe_id(input logic [3:0] op);
        return op[3:1];
    endfunction
endpackage

// File: rtl/omem_banked_if.sv
// Router-side packet ports plus host spike-drain port of the output memory.
interface omem_banked_if #(
    parameter int PKT_W  = 33,
    parameter int NUM_TS = 2,
    parameter int OUT_N  = 21
);
    localparam int TW = $clog2(NUM_TS) + 1;
    localparam int AW = $clog2(OUT_N * OUT_N);

    logic             pkt_in_valid;
    logic             pkt_in_ready;
    logic [PKT_W-1:0] pkt_in_data;
    logic             pkt_out_valid;
    logic             pkt_out_ready;
    logic [PKT_W-1:0] pkt_out_data;
    logic             drain_valid;
    logic             drain_ready;
    logic [TW-1:0]    drain_ts;
    logic [AW-1:0]    drain_addr;
    logic             drain_spike;
    logic             done;
    logic             err;

    modport master (
        input  pkt_in_valid, pkt_in_data, pkt_out_ready, drain_ready,
        output pkt_in_ready, pkt_out_valid, pkt_out_data,
        output drain_valid, drain_ts, drain_addr, drain_spike, done, err
    );

    modport slave (
        output pkt_in_valid, pkt_in_data, pkt_out_ready, drain_ready,
        input  pkt_in_ready, pkt_out_valid, pkt_out_data,
        input  drain_valid, drain_ts, drain_addr, drain_spike, done, err
    );
endinterface

// File: rtl/omem_bank_ram.sv
// Single-write, single-read memory; read is combinational so replies and drain beats need no extra stage.
module omem_bank_ram #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 1,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);
    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk)
        if (we) mem[waddr] <= wdata;

    assign rdata = mem[raddr];
endmodule

// File: rtl/omem_banked.sv
// Output memory for the SNN array: stores per-timestep spikes/residues, serves previous-timestep
// requests, broadcasts end-of-timestep and finally drains all spikes to the host.
module omem_banked
    import snn_pkg::*;
#(
    parameter int NUM_SPE     = 5,
    parameter int NUM_TS      = 2,
    parameter int OUT_N       = 21,
    parameter int SUM_W       = 13,
    parameter int SPE_BASE_ID = 0,
    parameter int NUM_NODES   = 11,
    parameter int PKT_W       = 33
) (
    input logic           clk,
    input logic           reset,
    omem_banked_if.master bus
);
    localparam int N2  = OUT_N * OUT_N;
    localparam int AW  = $clog2(N2);
    localparam int PW  = $clog2(N2 + NUM_SPE);
    localparam int CW  = $clog2(N2 + 1);
    localparam int TW  = $clog2(NUM_TS) + 1;
    localparam int BW  = $clog2(NUM_NODES + 1);
    localparam int SAW = $clog2(NUM_TS * N2);
    localparam int RAW = $clog2(2 * N2);

    omem_state_e state, nxt;
    logic [PW-1:0]    ptr [NUM_SPE];
    logic [CW-1:0]    store_cnt;
    logic [TW-1:0]    ts, drn_ts;
    logic [AW-1:0]    drn_addr;
    logic [BW-1:0]    bc_idx;
    logic [3:0]       req_op, in_op;
    logic [2:0]       in_k, req_k;
    logic [24:0]      in_data;
    logic [PW-1:0]    in_ptr, req_ptr;
    logic             err_q, in_acc, in_k_ok, in_store, in_req, in_ptr_ok, req_ptr_ok, rd_ok;
    logic             out_xfer, drn_xfer, bc_last, drn_last, ts_last;
    logic             wr_en, wr_spike, sp_rd;
    logic [SAW-1:0]   wr_sp_addr, sp_raddr;
    logic [RAW-1:0]   wr_res_addr, res_raddr;
    logic [SUM_W-1:0] wr_res, res_rd;
    pkt_t             out_pkt;
    logic             unused_bits;

    assign in_op       = bus.pkt_in_data[OP_HI:OP_LO];
    assign in_data     = bus.pkt_in_data[DATA_HI:DATA_LO];
    assign unused_bits = ^{bus.pkt_in_data[DEST_HI:DEST_LO], in_data[DATA_HI:SUM_W+1]};
    assign in_k        = op_spe_id(in_op);
    assign req_k       = op_spe_id(req_op);
    assign in_acc      = bus.pkt_in_valid && bus.pkt_in_ready;
    assign in_k_ok     = int'(in_k) < NUM_SPE;
    assign in_store    = in_acc && in_k_ok && op_is_store(in_op);
    assign in_req      = in_acc && in_k_ok && !op_is_store(in_op);
    assign out_xfer    = bus.pkt_out_valid && bus.pkt_out_ready;
    assign drn_xfer    = bus.drain_valid && bus.drain_ready;
    assign bc_last     = int'(bc_idx) == NUM_NODES - 1;
    assign drn_last    = int'(drn_ts) == NUM_TS - 1 && int'(drn_addr) == N2 - 1;
    assign ts_last     = int'(ts) == NUM_TS - 1;

    always_comb begin
        in_ptr  = '0;
        req_ptr = '0;
        for (int k = 0; k < NUM_SPE; k++) begin
            if (in_k == 3'(k))  in_ptr  = ptr[k];
            if (req_k == 3'(k)) req_ptr = ptr[k];
        end
    end
    assign in_ptr_ok  = int'(in_ptr) < N2;
    assign req_ptr_ok = int'(req_ptr) < N2;
    assign rd_ok      = (ts != '0) && req_ptr_ok;

    // Residue reads always target the bank the previous timestep wrote.
    always_comb begin
        if (state == ST_DRAIN) sp_raddr = SAW'(int'(drn_ts) * N2 + int'(drn_addr));
        else if (rd_ok)        sp_raddr = SAW'((int'(ts) - 1) * N2 + int'(req_ptr));
        else                   sp_raddr = '0;
        res_raddr = rd_ok ? RAW'((ts[0] ? 0 : N2) + int'(req_ptr)) : '0;
    end

    omem_bank_ram #(.DEPTH(NUM_TS * N2), .WIDTH(1)) u_spike (
        .clk(clk), .we(wr_en), .waddr(wr_sp_addr), .wdata(wr_spike),
        .raddr(sp_raddr), .rdata(sp_rd)
    );

    omem_bank_ram #(.DEPTH(2 * N2), .WIDTH(SUM_W)) u_res (
        .clk(clk), .we(wr_en), .waddr(wr_res_addr), .wdata(wr_res),
        .raddr(res_raddr), .rdata(res_rd)
    );

    always_ff @(posedge clk or posedge reset)
        if (reset) state <= ST_IDLE;
        else       state <= nxt;

    always_comb begin
        nxt = state;
        case (state)
            ST_IDLE:
                if (in_store && in_ptr_ok && int'(store_cnt) == N2 - 1) nxt = ST_BCAST;
                else if (in_req) nxt = ST_REPLY;
            ST_REPLY: if (out_xfer) nxt = ST_IDLE;
            ST_BCAST: if (out_xfer && bc_last) nxt = ts_last ? ST_DRAIN : ST_IDLE;
            ST_DRAIN: if (drn_xfer && drn_last) nxt = ST_DONE;
            default:  nxt = state;
        endcase
    end

    always_comb begin
        bus.pkt_in_ready  = 1'b0;
        bus.pkt_out_valid = 1'b0;
        bus.drain_valid   = 1'b0;
        bus.drain_ts      = '0;
        bus.drain_addr    = '0;
        bus.drain_spike   = 1'b0;
        bus.done          = 1'b0;
        out_pkt           = '0;
        case (state)
            ST_IDLE:  bus.pkt_in_ready = !reset;
            ST_REPLY: begin
                bus.pkt_out_valid = 1'b1;
                out_pkt.dest      = 4'(SPE_BASE_ID + int'(req_k));
                out_pkt.opcode    = req_op;
                if (rd_ok) begin
                    out_pkt.data[SUM_W:1] = res_rd;
                    out_pkt.data[0]       = sp_rd;
                end
            end
            ST_BCAST: begin
                bus.pkt_out_valid = 1'b1;
                out_pkt.dest      = 4'(bc_idx);
                out_pkt.opcode    = OP_TIMESTEP_DONE;
            end
            ST_DRAIN: begin
                bus.drain_valid = 1'b1;
                bus.drain_ts    = drn_ts + 1'b1;
                bus.drain_addr  = drn_addr;
                bus.drain_spike = sp_rd;
            end
            ST_DONE:  bus.done = 1'b1;
            default:  bus.done = 1'b0;
        endcase
        bus.pkt_out_data = PKT_W'(out_pkt);
    end

    assign bus.err = err_q;

    // Stores are registered and land in the memories one cycle after acceptance.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_SPE; k++) ptr[k] <= PW'(k);
            store_cnt   <= '0;
            ts          <= '0;
            drn_ts      <= '0;
            drn_addr    <= '0;
            bc_idx      <= '0;
            req_op      <= '0;
            err_q       <= 1'b0;
            wr_en       <= 1'b0;
            wr_sp_addr  <= '0;
            wr_res_addr <= '0;
            wr_spike    <= 1'b0;
            wr_res      <= '0;
        end else begin
            wr_en <= 1'b0;
            if (state == ST_IDLE && in_acc) begin
                if (!in_k_ok || !in_ptr_ok) err_q <= 1'b1;
                if (in_store && in_ptr_ok) begin
                    wr_en       <= 1'b1;
                    wr_sp_addr  <= SAW'(int'(ts) * N2 + int'(in_ptr));
                    wr_res_addr <= RAW'((ts[0] ? N2 : 0) + int'(in_ptr));
                    wr_spike    <= in_data[0];
                    wr_res      <= in_data[SUM_W:1];
                    store_cnt   <= store_cnt + 1'b1;
                    for (int k = 0; k < NUM_SPE; k++)
                        if (in_k == 3'(k)) ptr[k] <= in_ptr + PW'(NUM_SPE);
                end
                if (in_req) req_op <= in_op;
            end
            if (state == ST_BCAST && out_xfer) begin
                if (bc_last) begin
                    bc_idx    <= '0;
                    store_cnt <= '0;
                    for (int k = 0; k < NUM_SPE; k++) ptr[k] <= PW'(k);
                    if (!ts_last) ts <= ts + 1'b1;
                end else begin
                    bc_idx <= bc_idx + 1'b1;
                end
            end
            if (state == ST_DRAIN && drn_xfer) begin
                if (int'(drn_addr) == N2 - 1) begin
                    drn_addr <= '0;
                    drn_ts   <= drn_ts + 1'b1;
                end else begin
                    drn_addr <= drn_addr + 1'b1;
                end
            end
        end
    end
endmodule
